ped_crossing_ctrl: RTL and testbench
====================================

// Module: ped_crossing_ctrl
// PURPOSE
//  Downstream consumer of the traffic-light controller's red/yellow/green outputs.
//  Latches debounced pedestrian button presses and grants WALK only inside a vehicle red phase.
//  WALK is followed by a flashing DONT_WALK clearance, a remaining-time countdown, and a sticky fault on illegal light codes.
// PARAMETERS
//  TICK_DIV     100  clk cycles per timing tick (prescaler modulus, >=2)
//  WALK_TICKS   8    ticks of solid WALK
//  FLASH_TICKS  6    ticks of flashing DONT_WALK clearance
//  DEBOUNCE     4    consecutive stable synced samples needed to accept a button level
//  CNT_W        8    width of walk_count; WALK_TICKS+FLASH_TICKS < 2**CNT_W
// PORTS
//  clk          in   1      single clock; all logic on posedge
//  rst_n        in   1      synchronous, active-low reset
//  red          in   1      vehicle red from traffic light controller
//  yellow       in   1      vehicle yellow
//  green        in   1      vehicle green
//  ped_btn      in   1      raw asynchronous pedestrian button, active-high
//  walk         out  1      WALK lamp
//  dont_walk    out  1      DONT_WALK lamp (solid or flashing)
//  walk_count   out  CNT_W  remaining ticks of WALK+FLASH, 0 outside crossing
//  req_pending  out  1      request latched, awaiting service
//  fault        out  1      sticky illegal-light-code flag
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state IDLE, walk=0, dont_walk=1, walk_count=0, req_pending=0,
//   fault=0, prescaler=0, red_q=1 (red present at reset release is NOT a red edge), debounce cleared.
//  Button: 2-flop synchroniser -> debouncer; level accepted after DEBOUNCE equal samples; press = 0->1 of accepted level.
//  req_pending: set on press in IDLE or FLASH; press in WALK ignored; cleared on entry to WALK.
//  red_rise = red & ~red_q, red_q registered each cycle.
//  FSM (all outputs registered, 1-cycle latency from decision):
//   IDLE : walk=0, dont_walk=1. req_pending & red_rise -> WALK. Uses registered req_pending:
//          press in same cycle as red_rise waits for the next red phase.
//   WALK : walk=1, dont_walk=0. Entry loads walk_count=WALK_TICKS+FLASH_TICKS, prescaler=0.
//          Each tick (prescaler==TICK_DIV-1) walk_count-=1; after WALK_TICKS ticks -> FLASH.
//   FLASH: walk=0, dont_walk toggles every tick starting at 1; after FLASH_TICKS ticks -> IDLE, walk_count=0.
//   FAULT: walk=0, dont_walk=1, walk_count=0, fault=1; exit only via reset.
//  Safety abort: red=0 seen while in WALK or FLASH -> IDLE next cycle (walk=0, dont_walk=1, count=0);
//   req_pending keeps its value.
//  Fault: {red,yellow,green} not one-hot for 2 consecutive cycles -> FAULT from any state; has priority over all other transitions.
//  Prescaler runs only in WALK/FLASH; walk_count never wraps (saturates at 0).
//  Reset mid-crossing: immediate return to reset values; pending request discarded.
// STRUCTURE
//  Shared package traffic_pkg: ped_state_t (IDLE,WALK,FLASH,FAULT), light one-hot constants
//   (LIGHT_R=3'b100, LIGHT_Y=3'b010, LIGHT_G=3'b001), shared with the traffic light controller.
//  One sub-module: ped_debounce (sync + debounce + press pulse), parameter DEBOUNCE.
//  Top holds FSM, prescaler, countdown, fault detector.
// TESTING (bench params: TICK_DIV=4, WALK_TICKS=3, FLASH_TICKS=2, DEBOUNCE=2)
//  Reset: hold rst_n=0 with red=1 -> walk=0, dont_walk=1, walk_count=0, fault=0; no WALK after release without a press.
//  Normal: press during green, then red rises -> walk=1 one cycle after red_rise, walk_count=5; count 5,4,3 in WALK;
//   FLASH shows count 2,1 with dont_walk 1,0; then IDLE, count=0.
//  Bounce: ped_btn glitch 1-cycle high -> req_pending stays 0; 3-cycle high -> req_pending=1 within 5 cycles.
//  Late press: press in same cycle as red_rise -> no WALK this red; WALK on next red_rise.
//  Abort: red drops after 1 WALK tick -> walk=0, dont_walk=1, walk_count=0 next cycle, state IDLE.
//  Fault: drive red=1, green=1 for 2 cycles -> fault=1, dont_walk=1; stays set after legal lights until rst_n=0.

Source files
------------

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - state type and light codes shared with the traffic light controller
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        FLASH = 2'd2,
        FAULT = 2'd3
    } ped_state_t;

    localparam logic [2:0] LIGHT_R = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_G = 3'b001;

    function automatic logic light_legal(input logic [2:0] lights);
        return (lights == LIGHT_R) || (lights == LIGHT_Y) || (lights == LIGHT_G);
    endfunction

endpackage

// File: rtl/ped_debounce.sv
// rtl/ped_debounce.sv - button synchroniser, debouncer and single-cycle press pulse
module ped_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // cnt_q counts consecutive synced samples that disagree with the accepted level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            press_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEBOUNCE - 1)) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
                press_q <= sync2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/ped_crossing_ctrl.sv
// rtl/ped_crossing_ctrl.sv - pedestrian crossing FSM, tick prescaler, countdown and light fault detector
module ped_crossing_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV    = 100,
    parameter int WALK_TICKS  = 8,
    parameter int FLASH_TICKS = 6,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             ped_btn,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] walk_count,
    output logic             req_pending,
    output logic             fault
);

    localparam int               PW          = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] WALK_TOTAL  = CNT_W'(WALK_TICKS + FLASH_TICKS);
    localparam logic [CNT_W-1:0] FLASH_ENTRY = CNT_W'(FLASH_TICKS + 1);

    ped_state_t       state_q, state_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             walk_q, walk_d;
    logic             dw_q, dw_d;
    logic             req_q, req_d;
    logic             fault_q, fault_d;
    logic             red_q;
    logic             bad_q;
    logic             bad_now;
    logic             red_rise;
    logic             tick;
    logic             press;

    ped_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (ped_btn),
        .press_o (press)
    );

    assign bad_now  = !light_legal({red, yellow, green});
    assign red_rise = red & ~red_q;
    assign tick     = (pre_q == PW'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        pre_d   = '0;
        count_d = count_q;
        walk_d  = walk_q;
        dw_d    = dw_q;
        req_d   = req_q;
        fault_d = fault_q;

        if (press && (state_q == IDLE || state_q == FLASH)) begin
            req_d = 1'b1;
        end

        if (bad_now && bad_q) begin
            state_d = FAULT;
            walk_d  = 1'b0;
            dw_d    = 1'b1;
            count_d = '0;
            fault_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_q && red_rise) begin
                        state_d = WALK;
                        walk_d  = 1'b1;
                        dw_d    = 1'b0;
                        count_d = WALK_TOTAL;
                        req_d   = 1'b0;
                    end
                end
                WALK, FLASH: begin
                    if (!red) begin
                        state_d = IDLE;
                        walk_d  = 1'b0;
                        dw_d    = 1'b1;
                        count_d = '0;
                    end else begin
                        pre_d = tick ? '0 : pre_q + PW'(1);
                        if (tick) begin
                            if (count_q != '0) begin
                                count_d = count_q - CNT_W'(1);
                            end
                            // Phase boundaries are derived from the remaining count
                            if (state_q == WALK) begin
                                if (count_q == FLASH_ENTRY) begin
                                    state_d = FLASH;
                                    walk_d  = 1'b0;
                                    dw_d    = 1'b1;
                                end
                            end else if (count_q <= CNT_W'(1)) begin
                                state_d = IDLE;
                                dw_d    = 1'b1;
                                count_d = '0;
                            end else begin
                                dw_d = ~dw_q;
                            end
                        end
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            count_q <= '0;
            walk_q  <= 1'b0;
            dw_q    <= 1'b1;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
            red_q   <= 1'b1;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            count_q <= count_d;
            walk_q  <= walk_d;
            dw_q    <= dw_d;
            req_q   <= req_d;
            fault_q <= fault_d;
            red_q   <= red;
            bad_q   <= bad_now;
        end
    end

    assign walk        = walk_q;
    assign dont_walk   = dw_q;
    assign walk_count  = count_q;
    assign req_pending = req_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// tb/tb_ped_crossing_ctrl.sv - scoreboard bench for ped_crossing_ctrl
module tb_ped_crossing_ctrl;

    localparam int TICK_DIV    = 4;
    localparam int WALK_TICKS  = 3;
    localparam int FLASH_TICKS = 2;
    localparam int DEBOUNCE    = 2;
    localparam int CNT_W       = 8;

    localparam logic [4:0] M_ALL = 5'b11111;
    localparam logic [4:0] M_REQ = 5'b00010;
    localparam logic [4:0] M_FLT = 5'b00001;

    logic             clk     = 1'b0;
    logic             rst_n   = 1'b0;
    logic             red     = 1'b1;
    logic             yellow  = 1'b0;
    logic             green   = 1'b0;
    logic             ped_btn = 1'b0;
    logic             walk;
    logic             dont_walk;
    logic [CNT_W-1:0] walk_count;
    logic             req_pending;
    logic             fault;

    ped_crossing_ctrl #(
        .TICK_DIV    (TICK_DIV),
        .WALK_TICKS  (WALK_TICKS),
        .FLASH_TICKS (FLASH_TICKS),
        .DEBOUNCE    (DEBOUNCE),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .ped_btn     (ped_btn),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .walk_count  (walk_count),
        .req_pending (req_pending),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] tcyc;
        logic [4:0]  mask;
        logic        w;
        logic        dw;
        logic [7:0]  cnt;
        logic        req;
        logic        flt;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic cmp(input string t, input string f, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s got %0d expected %0d (cycle %0d)", t, f, act, req, cyc);
        end
    endtask

    // Monitor: outputs are stable at the falling edge; compare every expectation due this cycle
    exp_t  e;
    string t;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].tcyc <= 32'(cyc)) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e.tcyc != 32'(cyc)) begin
                checks++;
                errors++;
                $display("FAIL %s stale got cycle %0d expected cycle %0d", t, cyc, e.tcyc);
            end else begin
                if (e.mask[4]) cmp(t, "walk", 32'(walk), 32'(e.w));
                if (e.mask[3]) cmp(t, "dont_walk", 32'(dont_walk), 32'(e.dw));
                if (e.mask[2]) cmp(t, "walk_count", 32'(walk_count), 32'(e.cnt));
                if (e.mask[1]) cmp(t, "req_pending", 32'(req_pending), 32'(e.req));
                if (e.mask[0]) cmp(t, "fault", 32'(fault), 32'(e.flt));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // off = number of rising edges from now after which the outputs must show these values
    task automatic expect_at(input string tg, input int off, input logic [4:0] m,
                             input logic w, input logic dw, input int c, input logic r, input logic f);
        exp_t x;
        x.tcyc = 32'(cyc + off);
        x.mask = m;
        x.w    = w;
        x.dw   = dw;
        x.cnt  = 8'(c);
        x.req  = r;
        x.flt  = f;
        exp_q.push_back(x);
        tag_q.push_back(tg);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with red asserted; release must not count as a red edge
        step(1);
        expect_at("rst", 1, M_ALL, 0, 1, 0, 0, 0);
        step(2);
        rst_n = 1'b1;
        expect_at("rst_rel", 1, M_ALL, 0, 1, 0, 0, 0);
        expect_at("no_walk", 6, M_ALL, 0, 1, 0, 0, 0);
        step(6);

        // Normal crossing: press during green, then green -> yellow -> red
        red = 1'b0; green = 1'b1;
        step(2);
        ped_btn = 1'b1;
        expect_at("press_req", 5, M_REQ, 0, 0, 0, 1, 0);
        step(3);
        ped_btn = 1'b0;
        step(3);
        green = 1'b0; yellow = 1'b1;
        step(2);
        yellow = 1'b0; red = 1'b1;
        expect_at("walk_entry", 1,  M_ALL, 1, 0, 5, 0, 0);
        expect_at("walk_5b",    4,  M_ALL, 1, 0, 5, 0, 0);
        expect_at("walk_4",     5,  M_ALL, 1, 0, 4, 0, 0);
        expect_at("walk_3",     9,  M_ALL, 1, 0, 3, 0, 0);
        expect_at("walk_3b",    12, M_ALL, 1, 0, 3, 0, 0);
        expect_at("flash_2",    13, M_ALL, 0, 1, 2, 0, 0);
        expect_at("flash_1",    17, M_ALL, 0, 0, 1, 0, 0);
        expect_at("flash_1b",   20, M_ALL, 0, 0, 1, 0, 0);
        expect_at("idle_after", 21, M_ALL, 0, 1, 0, 0, 0);
        step(22);

        // Bounce: single-cycle glitch rejected, three-cycle press accepted
        ped_btn = 1'b1;
        step(1);
        ped_btn = 1'b0;
        expect_at("glitch_a", 4, M_REQ, 0, 0, 0, 0, 0);
        expect_at("glitch_b", 7, M_REQ, 0, 0, 0, 0, 0);
        step(8);
        ped_btn = 1'b1;
        expect_at("bounce3", 5, M_REQ, 0, 0, 0, 1, 0);
        step(3);
        ped_btn = 1'b0;
        step(4);

        // Abort: red drops after one WALK tick
        red = 1'b0; green = 1'b1;
        step(3);
        red = 1'b1; green = 1'b0;
        expect_at("abort_walk", 1, M_ALL, 1, 0, 5, 0, 0);
        expect_at("abort_tick", 5, M_ALL, 1, 0, 4, 0, 0);
        step(6);
        red = 1'b0; green = 1'b1;
        expect_at("abort",      1, M_ALL, 0, 1, 0, 0, 0);
        expect_at("abort_idle", 4, M_ALL, 0, 1, 0, 0, 0);
        step(4);

        // Late press: accepted press lands in the same cycle as red_rise
        ped_btn = 1'b1;
        step(3);
        ped_btn = 1'b0;
        step(1);
        red = 1'b1; green = 1'b0;
        expect_at("late_nowalk", 1, M_ALL, 0, 1, 0, 1, 0);
        expect_at("late_still",  4, M_ALL, 0, 1, 0, 1, 0);
        step(4);
        red = 1'b0; green = 1'b1;
        step(3);
        red = 1'b1; green = 1'b0;
        expect_at("late_walk", 1, M_ALL, 1, 0, 5, 0, 0);
        step(2);
        red = 1'b0; green = 1'b1;
        expect_at("late_abort", 1, M_ALL, 0, 1, 0, 0, 0);
        step(2);

        // Fault: one illegal cycle tolerated, two consecutive latch a sticky fault
        red = 1'b1;
        step(1);
        red = 1'b0;
        expect_at("glitch_nofault", 2, M_ALL, 0, 1, 0, 0, 0);
        step(3);
        red = 1'b1;
        expect_at("fault_pre", 1, M_FLT, 0, 0, 0, 0, 0);
        expect_at("fault",     2, M_ALL, 0, 1, 0, 0, 1);
        step(2);
        red = 1'b0;
        expect_at("fault_sticky", 3, M_ALL, 0, 1, 0, 0, 1);
        step(4);
        rst_n = 1'b0;
        expect_at("fault_rst", 1, M_ALL, 0, 1, 0, 0, 0);
        step(2);
        rst_n = 1'b1;
        expect_at("post_rst", 2, M_ALL, 0, 1, 0, 0, 0);
        step(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
